// File: rtl/plab5_mcore_mem_net_req_adapter_if.sv
// Request/network handshake bundle for plab5_mcore_mem_net_req_adapter.
// master = core/network side, slave = adapter side.
interface plab5_mcore_mem_net_req_adapter_if #(
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3
);
  localparam int LEN_NBITS  = $clog2(p_mem_data_nbits/8);
  localparam int REQ_NBITS  = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + LEN_NBITS + p_mem_data_nbits;
  localparam int CTRL_NBITS = REQ_NBITS - p_mem_data_nbits + 1 + p_net_opaque_nbits + 2*p_net_srcdest_nbits;

  logic                        mem_req_val;
  logic                        mem_req_rdy;
  logic [REQ_NBITS-1:0]        mem_req_msg;
  logic                        net_val;
  logic                        net_rdy;
  logic [CTRL_NBITS-1:0]       net_msg_control;
  logic [p_mem_data_nbits-1:0] net_msg_data;

  modport master (
    output mem_req_val, mem_req_msg, net_rdy,
    input  mem_req_rdy, net_val, net_msg_control, net_msg_data
  );

  modport slave (
    input  mem_req_val, mem_req_msg, net_rdy,
    output mem_req_rdy, net_val, net_msg_control, net_msg_data
  );
endinterface

// File: rtl/plab5_mcore_mem_net_req_adapter.sv
// Registered mem-request -> network adapter: bank steering, 2-entry FIFO, outstanding throttle.
// Optional per-source sequence tag in the net opaque field: PLAB5_MCORE_NET_REQ_SEQNUM_EN.
module plab5_mcore_mem_net_req_adapter #(
  parameter int p_net_src           = 0,
  parameter int p_num_banks         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_inst_bank_shift   = 14,
  parameter int p_data_bank_shift   = 15,
  parameter int p_max_outstanding   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mode,
  input  logic req_domain,
  input  logic resp_done,
  output logic [$clog2(p_max_outstanding+1)-1:0] outstanding,
  output logic underflow_err,
  plab5_mcore_mem_net_req_adapter_if.slave bus
);
  localparam int MO         = p_mem_opaque_nbits;
  localparam int MA         = p_mem_addr_nbits;
  localparam int MD         = p_mem_data_nbits;
  localparam int NO         = p_net_opaque_nbits;
  localparam int NS         = p_net_srcdest_nbits;
  localparam int LEN_NBITS  = $clog2(MD/8);
  localparam int ADDR_LSB   = MD + LEN_NBITS;
  localparam int OPQ_LSB    = ADDR_LSB + MA;
  localparam int REQ_NBITS  = OPQ_LSB + MO + 3;
  localparam int CTRL_NBITS = REQ_NBITS - MD + 1 + NO + 2*NS;
  localparam int CNT_NBITS  = $clog2(p_max_outstanding+1);
  localparam logic [NS-1:0] SRC_ID = NS'(p_net_src);

  logic                  enq;
  logic                  deq;
  logic [MA-1:0]         addr;
  logic [MA-1:0]         shifted;
  logic [NS-1:0]         dest;
  logic [MO-1:0]         opaque;
  logic [NO-1:0]         net_opaque;
  logic [CTRL_NBITS-1:0] ctrl_d;
  logic [CTRL_NBITS-1:0] ctrl_q [2];
  logic [MD-1:0]         data_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  assign addr = bus.mem_req_msg[OPQ_LSB-1:ADDR_LSB];

  // Bank clamp compares the full-width shifted address so high bits cannot alias onto a low bank.
  always_comb begin
    shifted = mode ? (addr >> p_data_bank_shift) : (addr >> p_inst_bank_shift);
    dest    = (shifted > MA'(p_num_banks - 1)) ? NS'(p_num_banks - 1) : shifted[NS-1:0];
    opaque  = {SRC_ID, bus.mem_req_msg[OPQ_LSB +: MO-NS]};
    ctrl_d  = {dest, SRC_ID, net_opaque, ~req_domain,
               bus.mem_req_msg[REQ_NBITS-1 -: 3], opaque, bus.mem_req_msg[OPQ_LSB-1:MD]};
  end

  // Ready uses pre-dequeue occupancy, so a full FIFO never sees enqueue and dequeue together.
  assign bus.mem_req_rdy     = (count != 2'd2) && (outstanding < CNT_NBITS'(p_max_outstanding));
  assign enq                 = bus.mem_req_val && bus.mem_req_rdy;
  assign bus.net_val         = (count != 2'd0);
  assign deq                 = bus.net_val && bus.net_rdy;
  assign bus.net_msg_control = ctrl_q[rd_ptr];
  assign bus.net_msg_data    = data_q[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q[0] <= '0;
      ctrl_q[1] <= '0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
    end else begin
      if (enq) begin
        ctrl_q[wr_ptr] <= ctrl_d;
        data_q[wr_ptr] <= bus.mem_req_msg[MD-1:0];
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding   <= '0;
      underflow_err <= 1'b0;
    end else if (enq && !resp_done) begin
      outstanding <= outstanding + CNT_NBITS'(1);
    end else if (!enq && resp_done) begin
      if (outstanding == '0) underflow_err <= 1'b1;
      else                   outstanding   <= outstanding - CNT_NBITS'(1);
    end
  end

`ifdef PLAB5_MCORE_NET_REQ_SEQNUM_EN
  logic [NO-1:0] seq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  seq_q <= '0;
    else if (enq)  seq_q <= seq_q + NO'(1);
  end

  assign net_opaque = seq_q;
`else
  assign net_opaque = '0;
`endif
endmodule

// File: tb/tb_plab5_mcore_mem_net_req_adapter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_plab5_mcore_mem_net_req_adapter;
  localparam int SRC = 2;
  localparam int NB  = 4;
  localparam int MAX = 4;

  typedef struct {
    logic [55:0] ctrl;
    logic [31:0] data;
  } flit_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mode;
  logic        req_domain;
  logic        resp_done;
  logic [2:0]  outstanding;
  logic        underflow_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  flit_t       q[$];
  int          m_out;
  logic        m_err;
  int unsigned m_seq;

  plab5_mcore_mem_net_req_adapter_if #(
    .p_mem_opaque_nbits(8), .p_mem_addr_nbits(32), .p_mem_data_nbits(32),
    .p_net_opaque_nbits(4), .p_net_srcdest_nbits(3)
  ) bus ();

  plab5_mcore_mem_net_req_adapter #(
    .p_net_src(SRC), .p_num_banks(NB), .p_max_outstanding(MAX),
    .p_inst_bank_shift(14), .p_data_bank_shift(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .req_domain(req_domain),
    .resp_done(resp_done), .outstanding(outstanding),
    .underflow_err(underflow_err), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [76:0] mk_msg(input logic [2:0] t, input logic [7:0] opq,
                                         input logic [31:0] a, input logic [1:0] len,
                                         input logic [31:0] d);
    return {t, opq, a, len, d};
  endfunction

  // Reference flit built from the field rules: bank = min(addr >> shift, NB-1), opaque top bits = SRC.
  function automatic flit_t exp_flit(input logic md, input logic dom, input logic [76:0] m,
                                     input int unsigned seq);
    flit_t       f;
    logic [31:0] a;
    longint      bank;
    logic [7:0]  op;
    logic [3:0]  tag;
    a    = m[65:34];
    bank = md ? longint'(a >> 15) : longint'(a >> 14);
    if (bank > NB - 1) bank = NB - 1;
    op   = {3'(SRC), m[70:66]};
`ifdef PLAB5_MCORE_NET_REQ_SEQNUM_EN
    tag  = 4'(seq);
`else
    tag  = 4'(seq * 0);
`endif
    f.ctrl = {3'(bank), 3'(SRC), tag, ~dom, m[76:74], op, m[65:32]};
    f.data = m[31:0];
    return f;
  endfunction

  task automatic step();
    logic  exp_rdy;
    logic  acc;
    logic  deq;
    flit_t f;
    @(negedge clk);
    exp_rdy = (q.size() < 2) && (m_out < MAX);
    check("net_val", 64'(bus.net_val), 64'(q.size() != 0));
    check("mem_req_rdy", 64'(bus.mem_req_rdy), 64'(exp_rdy));
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("underflow_err", 64'(underflow_err), 64'(m_err));
    if (q.size() != 0) begin
      check("head_ctrl", 64'(bus.net_msg_control), 64'(q[0].ctrl));
      check("head_data", 64'(bus.net_msg_data), 64'(q[0].data));
    end
    acc = bus.mem_req_val && exp_rdy;
    deq = (q.size() != 0) && bus.net_rdy;
    f   = exp_flit(mode, req_domain, bus.mem_req_msg, m_seq);
    @(posedge clk);
    if (acc) begin
      q.push_back(f);
      m_seq = (m_seq + 1) % 16;
    end
    if (deq) void'(q.pop_front());
    if (acc && !resp_done) m_out++;
    else if (!acc && resp_done) begin
      if (m_out == 0) m_err = 1'b1;
      else            m_out--;
    end
    #1;
  endtask

  task automatic async_reset_midstream();
    #2 reset_n = 1'b0;
    #1;
    check("rst_net_val", 64'(bus.net_val), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_rdy", 64'(bus.mem_req_rdy), 64'(1));
    q.delete();
    m_out = 0;
    m_err = 1'b0;
    m_seq = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b0; mode = 1'b0; req_domain = 1'b0; resp_done = 1'b0;
    bus.mem_req_val = 1'b0; bus.mem_req_msg = '0; bus.net_rdy = 1'b0;
    m_out = 0; m_err = 1'b0; m_seq = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    check("reset_net_val", 64'(bus.net_val), 64'(0));
    check("reset_outstanding", 64'(outstanding), 64'(0));
    check("reset_underflow", 64'(underflow_err), 64'(0));
    check("reset_rdy", 64'(bus.mem_req_rdy), 64'(1));
    check("reset_ctrl", 64'(bus.net_msg_control), 64'(0));
    check("reset_data", 64'(bus.net_msg_data), 64'(0));

    // Bank steering and field rewrite
    bus.mem_req_val = 1'b1; mode = 1'b1; req_domain = 1'b0;
    bus.mem_req_msg = mk_msg(3'd0, 8'hA5, 32'h0001_8000, 2'd0, 32'hDEAD_BEEF);
    step();
    bus.mem_req_val = 1'b0;
    check("dest_data_mode", 64'(bus.net_msg_control[55:53]), 64'(3));
    check("payload_msb", 64'(bus.net_msg_control[45]), 64'(1));
    check("mem_opaque", 64'(bus.net_msg_control[41:34]), 64'(8'h45));
    check("net_src", 64'(bus.net_msg_control[52:50]), 64'(2));
    bus.net_rdy = 1'b1;
    step();

    bus.mem_req_val = 1'b1; mode = 1'b0; req_domain = 1'b1;
    bus.mem_req_msg = mk_msg(3'd1, 8'h3C, 32'h0000_4000, 2'd1, 32'h1234_5678);
    step();
    bus.mem_req_val = 1'b0;
    check("dest_inst_mode", 64'(bus.net_msg_control[55:53]), 64'(1));
    step();

    bus.mem_req_val = 1'b1; mode = 1'b1;
    bus.mem_req_msg = mk_msg(3'd0, 8'h00, 32'hFFFF_0000, 2'd2, 32'h0);
    step();
    bus.mem_req_val = 1'b0;
    check("dest_clamped", 64'(bus.net_msg_control[55:53]), 64'(3));
    step();

    // Drain to zero, then one extra response underflows
    resp_done = 1'b1;
    repeat (4) step();
    resp_done = 1'b0;
    check("underflow_set", 64'(underflow_err), 64'(1));
    check("underflow_cnt", 64'(outstanding), 64'(0));
    step();

    // Asynchronous reset with traffic queued
    bus.net_rdy = 1'b0; bus.mem_req_val = 1'b1;
    repeat (2) step();
    bus.mem_req_val = 1'b0;
    async_reset_midstream();
    step();

    // Back-to-back until throttled, released by one response
    bus.net_rdy = 1'b1; bus.mem_req_val = 1'b1; mode = 1'b0;
    repeat (5) step();
    check("throttle_cnt", 64'(outstanding), 64'(4));
    check("throttle_rdy", 64'(bus.mem_req_rdy), 64'(0));
    resp_done = 1'b1;
    step();
    resp_done = 1'b0;
    check("release_rdy", 64'(bus.mem_req_rdy), 64'(1));
    step();
    bus.mem_req_val = 1'b0;
    check("fifth_accepted", 64'(outstanding), 64'(4));

    resp_done = 1'b1;
    repeat (2) step();
    bus.mem_req_val = 1'b1;
    step();
    bus.mem_req_val = 1'b0; resp_done = 1'b0;
    check("acc_and_done", 64'(outstanding), 64'(2));
    step();

    // Network backpressure with a full FIFO
    bus.net_rdy = 1'b0; bus.mem_req_val = 1'b1;
    bus.mem_req_msg = mk_msg(3'd2, 8'h11, 32'h0000_8000, 2'd0, 32'hAAAA_0001);
    step();
    bus.mem_req_msg = mk_msg(3'd3, 8'h22, 32'h0000_C000, 2'd3, 32'hAAAA_0002);
    step();
    repeat (3) step();
    check("full_rdy", 64'(bus.mem_req_rdy), 64'(0));
    bus.mem_req_val = 1'b0; bus.net_rdy = 1'b1;
    repeat (3) step();
    resp_done = 1'b1;
    repeat (4) step();
    resp_done = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom & 32'h0001_FFFF;
        1:       a = $urandom;
        default: a = $urandom & 32'h0000_7FFF;
      endcase
      bus.mem_req_val = ($urandom_range(0, 3) != 0);
      mode            = 1'($urandom);
      req_domain      = 1'($urandom);
      bus.mem_req_msg = mk_msg(3'($urandom), 8'($urandom), a, 2'($urandom), $urandom);
      bus.net_rdy     = ($urandom_range(0, 3) != 0);
      resp_done       = (m_out > 0) && ($urandom_range(0, 2) == 0);
      step();
    end
    bus.mem_req_val = 1'b0; resp_done = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
